// File: rtl/fpu_pkg.sv
// Shared definitions for the fixed-point unit and its issue stage:
// opcode constants, issue FSM state encoding, default timeout and a
// saturating counter helper.
package fpu_pkg;

    typedef logic [1:0] fpu_op_t;

    localparam fpu_op_t OP_ADD  = 2'b00;
    localparam fpu_op_t OP_SUB  = 2'b01;
    localparam fpu_op_t OP_MUL  = 2'b10;
    localparam fpu_op_t OP_SQRT = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ISSUE = 2'b01;
    localparam logic [1:0] ST_WAIT  = 2'b10;
    localparam logic [1:0] ST_RESP  = 2'b11;

    localparam int DEFAULT_TIMEOUT = 64;

    // Increment a 16-bit count, sticking at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] next;
        if (value == 16'hFFFF) begin
            next = value;
        end else begin
            next = value + 16'd1;
        end
        return next;
    endfunction

endpackage

// File: rtl/fixed_point_issue_if.sv
// Request / fixed-point-unit / response signal bundle of the issue stage.
// The issue block uses the slave modport; its environment uses master.
interface fixed_point_issue_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [TAG_W-1:0] req_tag;

    logic [WIDTH-1:0] fpu_operand_1;
    logic [WIDTH-1:0] fpu_operand_2;
    logic [1:0]       fpu_operation;
    logic [WIDTH-1:0] fpu_result;
    logic             fpu_ready;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_error;
    logic [15:0]      ops_done;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag,
        input  fpu_result, fpu_ready, rsp_ready,
        output req_ready, fpu_operand_1, fpu_operand_2, fpu_operation,
        output rsp_valid, rsp_result, rsp_tag, rsp_error, ops_done
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag,
        output fpu_result, fpu_ready, rsp_ready,
        input  req_ready, fpu_operand_1, fpu_operand_2, fpu_operation,
        input  rsp_valid, rsp_result, rsp_tag, rsp_error, ops_done
    );
endinterface

// File: rtl/fixed_point_issue_timer.sv
// WAIT-state watchdog for the issue stage. Cleared while the FSM is in
// ISSUE (i.e. on entry to WAIT), counts each WAIT cycle, and flags
// expiry during the TIMEOUT-th WAIT cycle so the FSM leaves on that edge.
module fixed_point_issue_timer
    import fpu_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise count up while enabled and stick at the limit.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {CW{1'b0}};
        end else if (enable && (count_q != CW'(TIMEOUT))) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register, zeroed asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fixed_point_issue.sv
// Issue stage in front of a fixed-point unit: accepts one tagged request,
// drives it to the unit for a settle cycle, waits for fpu_ready, and
// returns the captured result with the original tag.
// Optional feature macro: FPU_TIMEOUT_EN -- when defined, a WAIT-cycle
// watchdog ends a stalled operation after TIMEOUT cycles with
// rsp_error=1 and rsp_result=0; otherwise WAIT lasts until fpu_ready.
module fixed_point_issue
    import fpu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    fixed_point_issue_if.slave bus
);
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic [1:0]       opn_q, opn_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic [15:0]      ops_q, ops_d;

`ifdef FPU_TIMEOUT_EN
    logic error_q, error_d;
    logic timer_clear_s;
    logic timer_en_s;
    logic timer_expired_s;

    fixed_point_issue_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear_s),
        .enable  (timer_en_s),
        .expired (timer_expired_s)
    );
`endif

    // FSM next state plus capture of request, result and completion count.
    always_comb begin
        state_d  = state_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        opn_d    = opn_q;
        tag_d    = tag_q;
        result_d = result_q;
        ops_d    = ops_q;
`ifdef FPU_TIMEOUT_EN
        error_d       = error_q;
        timer_clear_s = 1'b0;
        timer_en_s    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && ready_q) begin
                    op1_d   = bus.req_a;
                    op2_d   = bus.req_b;
                    opn_d   = bus.req_op;
                    tag_d   = bus.req_tag;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // Settle cycle: fpu_ready is deliberately not looked at here.
                state_d = ST_WAIT;
`ifdef FPU_TIMEOUT_EN
                timer_clear_s = 1'b1;
`endif
            end
            ST_WAIT: begin
`ifdef FPU_TIMEOUT_EN
                timer_en_s = 1'b1;
`endif
                if (bus.fpu_ready) begin
                    result_d = bus.fpu_result;
`ifdef FPU_TIMEOUT_EN
                    error_d  = 1'b0;
`endif
                    state_d  = ST_RESP;
`ifdef FPU_TIMEOUT_EN
                end else if (timer_expired_s) begin
                    result_d = {WIDTH{1'b0}};
                    error_d  = 1'b1;
                    state_d  = ST_RESP;
`endif
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    ops_d   = sat_inc16(ops_q);
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        valid_d = (state_d == ST_RESP);
        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers, forced to their idle values by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            op1_q    <= {WIDTH{1'b0}};
            op2_q    <= {WIDTH{1'b0}};
            opn_q    <= OP_ADD;
            tag_q    <= {TAG_W{1'b0}};
            result_q <= {WIDTH{1'b0}};
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            ops_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            opn_q    <= opn_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            ops_q    <= ops_d;
        end
    end

`ifdef FPU_TIMEOUT_EN
    // Timeout flag register, cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign bus.rsp_error = error_q;
`else
    assign bus.rsp_error = 1'b0;
`endif

    assign bus.req_ready     = ready_q;
    assign bus.fpu_operand_1 = op1_q;
    assign bus.fpu_operand_2 = op2_q;
    assign bus.fpu_operation = opn_q;
    assign bus.rsp_valid     = valid_q;
    assign bus.rsp_result    = result_q;
    assign bus.rsp_tag       = tag_q;
    assign bus.ops_done      = ops_q;

endmodule

// File: tb/tb_fixed_point_issue.sv
// Self-checking bench for fixed_point_issue: a directed vector table,
// hand-written reset/timeout sequences and randomized requests compared
// against an arithmetic model of the fixed-point unit.
module tb_fixed_point_issue;
    import fpu_pkg::*;

    localparam int W  = 32;
    localparam int TW = 5;
    localparam int TO = 8;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   exp_ops;

    fixed_point_issue_if #(.WIDTH(W), .TAG_W(TW)) bus ();

    fixed_point_issue #(
        .WIDTH   (W),
        .TAG_W   (TW),
        .TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Arithmetic meaning of each operation on unsigned WIDTH-bit words.
    function automatic logic [31:0] fpu_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        logic [63:0] t;
        case (op)
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
            OP_MUL: r = a * b;
            default: begin
                r = 32'd0;
                for (int k = 15; k >= 0; k--) begin
                    t = {32'd0, r | (32'd1 << k)};
                    if (t * t <= {32'd0, a}) r = t[31:0];
                end
            end
        endcase
        return r;
    endfunction

    // The stand-in fixed-point unit computes from what the DUT drives to it.
    assign bus.fpu_result = fpu_model(bus.fpu_operation, bus.fpu_operand_1, bus.fpu_operand_2);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full transaction, started at a negedge with the DUT idle.
    task automatic run_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag, input int issue_rdy, input int delay,
                           input int hold, input logic [31:0] exp_res, input logic exp_err,
                           input int exp_lat);
        int i;
        chk("req_ready_before", {63'd0, bus.req_ready}, 64'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_a     = 32'hDEAD_BEEF;
        bus.req_b     = 32'hCAFE_F00D;
        bus.req_tag   = 5'd0;
        chk("req_ready_busy", {63'd0, bus.req_ready}, 64'd0);
        i = 1;
        while (i <= 300) begin
            bus.fpu_ready = (i == 1) ? (issue_rdy != 0) : ((i - 1) > delay);
            @(negedge clk);
            if (bus.rsp_valid) break;
            i++;
        end
        bus.fpu_ready = 1'b0;
        chk("rsp_latency", 64'(i + 1), 64'(exp_lat));
        for (int h = 0; h <= hold; h++) begin
            chk("rsp_valid_hold", {63'd0, bus.rsp_valid}, 64'd1);
            chk("rsp_result", {32'd0, bus.rsp_result}, {32'd0, exp_res});
            chk("rsp_tag", {59'd0, bus.rsp_tag}, {59'd0, tag});
            chk("rsp_error", {63'd0, bus.rsp_error}, {63'd0, exp_err});
            chk("ops_done_hold", {48'd0, bus.ops_done}, 64'(exp_ops));
            bus.rsp_ready = (h == hold);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b0;
        if (exp_ops < 65535) exp_ops++;
        chk("ops_done", {48'd0, bus.ops_done}, 64'(exp_ops));
        chk("rsp_valid_after", {63'd0, bus.rsp_valid}, 64'd0);
        chk("req_ready_after", {63'd0, bus.req_ready}, 64'd1);
        chk("operand_1_hold", {32'd0, bus.fpu_operand_1}, {32'd0, a});
        chk("operand_2_hold", {32'd0, bus.fpu_operand_2}, {32'd0, b});
        chk("operation_hold", {62'd0, bus.fpu_operation}, {62'd0, op});
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        int          issue_rdy;
        int          delay;
        int          hold;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rtag;
        int          rdel;

        errors = 0;
        checks = 0;
        exp_ops = 0;
        clk = 1'b0;
        reset = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_ADD;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        bus.req_tag   = 5'd0;
        bus.fpu_ready = 1'b0;
        bus.rsp_ready = 1'b0;

        // ADD held ready, long SQRT wait with held response, ISSUE-only ready, SUB wrap, large MUL
        vecs[0] = '{OP_ADD,  32'd5,   32'd7, 5'd3,  1, 0, 0, 32'd12,         3};
        vecs[1] = '{OP_SQRT, 32'd144, 32'd9, 5'd17, 0, 9, 4, 32'd12,         12};
        vecs[2] = '{OP_MUL,  32'd6,   32'd7, 5'd31, 1, 2, 1, 32'd42,         5};
        vecs[3] = '{OP_SUB,  32'd3,   32'd5, 5'd0,  0, 0, 2, 32'hFFFF_FFFE,  3};
        vecs[4] = '{OP_MUL,  32'h0001_0001, 32'h0001_0000, 5'd12, 1, 1, 0, 32'h0001_0000, 4};

        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("reset_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("reset_ops_done", {48'd0, bus.ops_done}, 64'd0);
        chk("reset_operation", {62'd0, bus.fpu_operation}, {62'd0, OP_ADD});
        chk("reset_operand_1", {32'd0, bus.fpu_operand_1}, 64'd0);
        chk("reset_result", {32'd0, bus.rsp_result}, 64'd0);
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            run_txn(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].tag, vecs[v].issue_rdy,
                    vecs[v].delay, vecs[v].hold, vecs[v].exp_res, 1'b0, vecs[v].exp_lat);
        end

`ifdef FPU_TIMEOUT_EN
        // fpu_ready never arrives: watchdog ends WAIT after TO cycles
        run_txn(OP_MUL, 32'd9, 32'd9, 5'd21, 0, 1000, 1, 32'd0, 1'b1, 2 + TO);
        // a late-but-in-time ready still returns a normal result
        run_txn(OP_ADD, 32'd1, 32'd2, 5'd22, 0, TO - 1, 0, 32'd3, 1'b0, 2 + TO);
`else
        // WAIT keeps waiting well past any timeout value
        run_txn(OP_MUL, 32'd9, 32'd9, 5'd21, 0, 3 * TO, 1, 32'd81, 1'b0, 3 + 3 * TO);
`endif

        // Reset while waiting: everything clears, no response, then normal service.
        bus.req_valid = 1'b1;
        bus.req_op    = OP_MUL;
        bus.req_a     = 32'd3;
        bus.req_b     = 32'd4;
        bus.req_tag   = 5'd9;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.fpu_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        exp_ops = 0;
        chk("async_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("async_rsp_result", {32'd0, bus.rsp_result}, 64'd0);
        chk("async_rsp_tag", {59'd0, bus.rsp_tag}, 64'd0);
        chk("async_rsp_error", {63'd0, bus.rsp_error}, 64'd0);
        chk("async_operand_1", {32'd0, bus.fpu_operand_1}, 64'd0);
        chk("async_operand_2", {32'd0, bus.fpu_operand_2}, 64'd0);
        chk("async_operation", {62'd0, bus.fpu_operation}, {62'd0, OP_ADD});
        chk("async_ops_done", {48'd0, bus.ops_done}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_reset_req_ready", {63'd0, bus.req_ready}, 64'd1);
        bus.fpu_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("dropped_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
        end
        bus.fpu_ready = 1'b0;
        run_txn(OP_ADD, 32'd100, 32'd23, 5'd9, 0, 0, 0, 32'd123, 1'b0, 3);

        // Randomized requests against the arithmetic model.
        for (int r = 0; r < 25; r++) begin
            rop  = 2'($urandom_range(0, 3));
            ra   = $urandom;
            rb   = $urandom;
            rtag = 5'($urandom_range(0, 31));
            rdel = $urandom_range(0, 4);
            run_txn(rop, ra, rb, rtag, $urandom_range(0, 1), rdel, $urandom_range(0, 2),
                    fpu_model(rop, ra, rb), 1'b0, 3 + rdel);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fixed_point_issue.md
FIXED_POINT_ISSUE -- requirements
Module: fixed_point_issue

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, operand/result width; TAG_W, default 5, request tag width; TIMEOUT, default 64, max wait cycles for fpu_ready.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_op  input  2  operation code: ADD, SUB, MUL or SQRT.
REQ-007 req_a, req_b  input  WIDTH each  fixed-point operands.
REQ-008 req_tag  input  TAG_W  requester tag, returned unchanged.
REQ-009 fpu_operand_1, fpu_operand_2  output  WIDTH each  operands driven to the fixed-point unit.
REQ-010 fpu_operation  output  2  operation driven to the fixed-point unit.
REQ-011 fpu_result  input  WIDTH  fixed-point unit result.
REQ-012 fpu_ready  input  1  fixed-point unit result valid.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts response.
REQ-015 rsp_result, rsp_tag, rsp_error  output  WIDTH, TAG_W, 1  captured result, tag, timeout flag.
REQ-016 ops_done  output  16  saturating count of completed responses.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge with req_valid & req_ready.
REQ-019 On acceptance, the block SHALL register req_a, req_b and req_op onto fpu_operand_1/2 and fpu_operation, latch req_tag, and go to ISSUE.
REQ-020 ISSUE SHALL last exactly one cycle with fpu_ready ignored (settle cycle), then go to WAIT.
REQ-021 In WAIT, the first edge with fpu_ready=1 SHALL capture fpu_result into rsp_result, clear rsp_error and go to RESP.
REQ-022 Minimum latency SHALL be: rsp_valid high in the third cycle after the acceptance edge.
REQ-023 In RESP, rsp_valid SHALL be 1 and rsp_result, rsp_tag and rsp_error SHALL hold stable until an edge with rsp_ready=1; on that edge the FSM SHALL go to IDLE and ops_done SHALL increment, saturating at 16'hFFFF.
REQ-024 fpu_operand_1/2 and fpu_operation SHALL hold their last values in every state until the next acceptance.
REQ-025 There SHALL be no same-cycle bypass; back-to-back requests are separated by at least one IDLE cycle.

Reset
REQ-026 Reset asserted SHALL, asynchronously and in any state, force: FSM to IDLE; rsp_valid, rsp_error, rsp_result, rsp_tag, fpu_operand_1/2 and ops_done to 0; fpu_operation to ADD; timeout counter to 0.
REQ-027 A request in flight during reset SHALL be dropped with no response.
REQ-028 req_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-029 With FPU_TIMEOUT_EN defined, the block SHALL count WAIT cycles with a counter that is reset on entry to WAIT.
REQ-030 With FPU_TIMEOUT_EN defined, if TIMEOUT WAIT cycles elapse without fpu_ready, the block SHALL go to RESP with rsp_error=1 and rsp_result=0.
REQ-031 Without FPU_TIMEOUT_EN, the block SHALL contain no counter, rsp_error SHALL be tied 0, and WAIT SHALL last indefinitely.

Structure
REQ-032 Opcode constants (ADD=2'b00, SUB=2'b01, MUL=2'b10, SQRT=2'b11), FSM state encoding and default TIMEOUT SHALL live in shared package fpu_pkg, common with the fixed-point unit.
REQ-033 The timeout counter SHALL be a sub-module fixed_point_issue_timer (inputs: clear, enable; output: expired), instantiated only under FPU_TIMEOUT_EN.

Verification
REQ-034 ADD 5 + 7, tag 3, fpu_ready held 1 -> rsp_valid in 3rd cycle after acceptance, rsp_result=12, rsp_tag=3, rsp_error=0.
REQ-035 SQRT request, fpu_ready rises 10 cycles after ISSUE, rsp_ready held 0 for 4 cycles -> response is held stable for those 4 cycles, then ops_done=1 and req_ready=1 in the next cycle.
REQ-036 fpu_ready=1 during ISSUE only, then 0 for 2 cycles, then 1 -> result is captured only in WAIT, with no early response.
REQ-037 With FPU_TIMEOUT_EN, TIMEOUT=8, fpu_ready held 0 -> rsp_error=1 and rsp_result=0 after 8 WAIT cycles.
REQ-038 Reset asserted in WAIT -> all outputs 0 immediately (fpu_operation=ADD), no response, and the next request completes normally.
